// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier controller.
package booth_pkg;

  localparam int unsigned Width = 8;
  localparam int unsigned Iter  = 8;
  localparam int unsigned CntW  = 3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} booth_state_e;

  typedef enum logic [1:0] {OpNop, OpAdd, OpSub} booth_op_e;

  // Radix-2 Booth recoding of the pair {Q[0], Q_1}.
  function automatic booth_op_e booth_decode(input logic q0, input logic q1);
    unique case ({q0, q1})
      2'b10:   return OpSub;
      2'b01:   return OpAdd;
      default: return OpNop;
    endcase
  endfunction

endpackage

// File: rtl/booth_ctrl_cla.sv
// 8-bit carry-lookahead adder; every carry is a flat sum of generate/propagate products.
module booth_ctrl_cla
  import booth_pkg::*;
(
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] g;
  logic [Width-1:0] p;
  logic [Width-1:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Carry-out of the top bit is not needed by the multiplier, so only c[0..Width-1] exist.
  always_comb begin
    logic pp;
    c    = '0;
    pp   = 1'b0;
    c[0] = cin_i;
    for (int i = 0; i < Width - 1; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin_i);
    end
  end

  assign sum_o = p ^ c;

endmodule

// File: rtl/booth_ctrl.sv
// Sequential 8x8 signed radix-2 Booth multiplier controller sharing one CLA over 8 iterations.
module booth_ctrl
  import booth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [Width-1:0]     multiplicand,
  input  logic [Width-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*Width-1:0]   product
);

  booth_state_e state_q, state_d;
  logic [Width-1:0]   a_q, a_d;
  logic [Width-1:0]   q_q, q_d;
  logic [Width-1:0]   m_q, m_d;
  logic               q1_q, q1_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*Width-1:0] product_q, product_d;

  booth_op_e        op;
  logic [Width-1:0] cla_b;
  logic             cla_cin;
  logic [Width-1:0] cla_s;
  logic             ovf;
  logic [Width-1:0] a_next;
  logic [Width-1:0] q_next;

  always_comb begin
    op = booth_decode(q_q[0], q1_q);
    unique case (op)
      OpSub: begin
        cla_b   = ~m_q;
        cla_cin = 1'b1;
      end
      OpAdd: begin
        cla_b   = m_q;
        cla_cin = 1'b0;
      end
      default: begin
        cla_b   = '0;
        cla_cin = 1'b0;
      end
    endcase
  end

  booth_ctrl_cla u_cla (
    .a_i   (a_q),
    .b_i   (cla_b),
    .cin_i (cla_cin),
    .sum_o (cla_s)
  );

  // The 8-bit sum can overflow (e.g. M=-128); shift in the true 9th bit, not S[7].
  assign ovf    = (a_q[Width-1] == cla_b[Width-1]) && (cla_s[Width-1] != a_q[Width-1]);
  assign a_next = {cla_s[Width-1] ^ ovf, cla_s[Width-1:1]};
  assign q_next = {cla_s[0], q_q[Width-1:1]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    q1_d      = q1_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = done_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = CntW'(Iter - 1);
          state_d = StRun;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        a_d     = a_next;
        q_d     = q_next;
        q1_d    = q_q[0];
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
          product_d = {a_next, q_next};
          state_d   = StDone;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed, table-driven bench for booth_ctrl: products, latency and handshake corners.
module tb_booth_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks;
  int failures;

  booth_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts from IDLE; checks busy length, done timing, product and the done fall.
  task automatic do_mul(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp,
                        input string name);
    int busy_cnt;
    int done_idx;
    busy_cnt = 0;
    done_idx = -1;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    for (int n = 0; n < 20 && done_idx < 0; n++) begin
      if (n > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_idx = n;
    end
    check({name, "_busy_cycles"}, busy_cnt, 8);
    check({name, "_done_cycle"}, done_idx, 8);
    check({name, "_product"}, {16'h0, product}, {16'h0, exp});
    @(negedge clk);
    check({name, "_done_fall"}, {31'h0, done}, 0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_idx;
    int done_at[$];
    logic [15:0] held;

    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    vecs[0] = '{8'd3,    8'd5,    16'h000F, "3x5"};
    vecs[1] = '{8'hFD,   8'd5,    16'hFFF1, "m3x5"};
    vecs[2] = '{8'd7,    8'hFF,   16'hFFF9, "7xm1"};
    vecs[3] = '{8'h80,   8'h80,   16'h4000, "m128xm128"};
    vecs[4] = '{8'd127,  8'h80,   16'hC080, "127xm128"};
    vecs[5] = '{8'd0,    8'hB3,   16'h0000, "0xm77"};
    vecs[6] = '{8'hFF,   8'hFF,   16'h0001, "m1xm1"};
    vecs[7] = '{8'd127,  8'd127,  16'h3F01, "127x127"};
    vecs[8] = '{8'h80,   8'd127,  16'hC080, "m128x127"};
    vecs[9] = '{8'd10,   8'd10,   16'h0064, "10x10"};

    repeat (2) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 0);
    check("reset_done", {31'h0, done}, 0);
    check("reset_product", {16'h0, product}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_mul(vecs[i].m, vecs[i].q, vecs[i].p, vecs[i].name);

    // start presented during RUN and across the DONE cycle must be ignored.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 8'd6;
    multiplier   = 8'd6;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = -1;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = n;
      end
      if (n == 3) begin
        start        = 1'b1;
        multiplicand = 8'd9;
        multiplier   = 8'd9;
      end
      if (n == 9) start = 1'b0;
    end
    check("hs_busy_cycles", busy_cnt, 8);
    check("hs_done_count", done_cnt, 1);
    check("hs_done_cycle", done_idx, 8);
    check("hs_product", {16'h0, product}, 32'h0024);

    // Reset in the middle of a run aborts it without a done pulse.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 8'd10;
    multiplier   = 8'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_done", {31'h0, done}, 0);
    check("abort_product", {16'h0, product}, 0);
    done_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("abort_stays_idle", done_cnt, 0);
    do_mul(8'd10, 8'd10, 16'h0064, "after_abort");

    // rst and start together: rst wins.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", {31'h0, busy}, 0);
    @(negedge clk);
    check("rst_start_busy_later", {31'h0, busy}, 0);

    // start held high: one accepted multiply every 10 cycles.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 8'd2;
    multiplier   = 8'd3;
    @(posedge clk);
    held = 16'h0000;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(n);
        check("b2b_product", {16'h0, product}, 32'h0006);
        held = product;
      end else if (done_at.size() > 0) begin
        check("b2b_product_stable", {16'h0, product}, {16'h0, held});
      end
      if (n == 29) start = 1'b0;
    end
    check("b2b_done_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      check("b2b_first_done", done_at[0], 8);
      check("b2b_spacing_1", done_at[1] - done_at[0], 10);
      check("b2b_spacing_2", done_at[2] - done_at[1], 10);
    end
    repeat (12) @(negedge clk);
    check("b2b_final_idle", {31'h0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
